// File: rtl/roce_stack_addr_lookup_arbiter.sv
// Round-robin arbiter sharing the translation-table lookup port between the RoCE
// read-path (0) and write-path (1) handlers, with in-order response steering.

package roce_stack_addr_lookup_arbiter_pkg;
    typedef struct packed {
        logic [63:0] paddr;
        logic [31:0] len;
        logic [15:0] qpn;
    } dma_req_t;
endpackage

module roce_stack_addr_lookup_arbiter_chk (
    input  logic       clk_i,
    input  logic       aresetn_i,
    input  logic       push,
    input  logic [1:0] cnt
);
    // A push into a full order FIFO means a requester had two lookups in flight.
    assert property (@(posedge clk_i) disable iff (!aresetn_i) !(push && (cnt == 2'd2)))
        else $error("order fifo overflow");
endmodule

module roce_stack_addr_lookup_arbiter
    import roce_stack_addr_lookup_arbiter_pkg::*;
(
    input  logic             clk_i,
    input  logic             aresetn_i,
    input  logic [1:0]       rq_valid_i,
    output logic [1:0]       rq_ready_o,
    input  logic [1:0][63:0] rq_vaddr_i,
    input  logic [1:0][15:0] rq_qpn_i,
    output logic [1:0]       rsp_valid_o,
    input  logic [1:0]       rsp_ready_i,
    output dma_req_t         rsp_data_o,
    output logic             req_addr_valid_o,
    input  logic             req_addr_ready_i,
    output logic [63:0]      req_addr_vaddr_o,
    output logic [15:0]      req_addr_qpn_o,
    input  logic             resp_addr_valid_i,
    output logic             resp_addr_ready_o,
    input  dma_req_t         resp_addr_data_i,
    output logic             err_orphan_o
);

    logic [1:0]  pending_r;
    logic        rr_r;
    logic        out_valid_r;
    logic [63:0] out_vaddr_r;
    logic [15:0] out_qpn_r;
    logic [1:0]  fifo_r;
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  cnt_r;
    logic        err_r;

    logic [1:0]  elig_s;
    logic        grant_s;
    logic        winner_s;
    logic        head_s;
    logic        has_head_s;
    logic        pop_s;
    logic        orphan_s;
    logic [1:0]  pending_nxt_s;

    assign elig_s     = rq_valid_i & ~pending_r;
    assign head_s     = fifo_r[rd_ptr_r];
    assign has_head_s = (cnt_r != 2'd0);
    assign grant_s    = (elig_s != 2'b00) && (!out_valid_r || req_addr_ready_i);

    // Winner selection: round-robin pointer only matters under contention.
    always_comb begin
        winner_s = 1'b0;
        case (elig_s)
            2'b01:   winner_s = 1'b0;
            2'b10:   winner_s = 1'b1;
            2'b11:   winner_s = rr_r;
            default: winner_s = 1'b0;
        endcase
    end

    // Response steering toward the requester at the head of the order FIFO.
    always_comb begin
        rsp_valid_o       = 2'b00;
        resp_addr_ready_o = 1'b1;
        pop_s             = 1'b0;
        orphan_s          = 1'b0;
        if (has_head_s) begin
            rsp_valid_o[head_s] = resp_addr_valid_i;
            resp_addr_ready_o   = rsp_ready_i[head_s];
            pop_s               = resp_addr_valid_i && rsp_ready_i[head_s];
        end else begin
            orphan_s = resp_addr_valid_i;
        end
    end

    // Pending mask next state; the granted and popped requesters always differ.
    always_comb begin
        pending_nxt_s = pending_r;
        if (pop_s) begin
            pending_nxt_s[head_s] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (grant_s) begin
            pending_nxt_s[winner_s] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // Output slot, arbitration pointer, order FIFO and sticky error state.
    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            pending_r   <= 2'b00;
            rr_r        <= 1'b0;
            out_valid_r <= 1'b0;
            out_vaddr_r <= 64'h0;
            out_qpn_r   <= 16'h0;
            fifo_r      <= 2'b00;
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            cnt_r       <= 2'd0;
            err_r       <= 1'b0;
        end else begin
            if (grant_s) begin
                out_valid_r <= 1'b1;
                out_vaddr_r <= rq_vaddr_i[winner_s];
                out_qpn_r   <= rq_qpn_i[winner_s];
                fifo_r[wr_ptr_r] <= winner_s;
                wr_ptr_r    <= wr_ptr_r + 1'b1;
                if (elig_s == 2'b11) begin
                    rr_r <= ~rr_r;
                end
            end else if (req_addr_ready_i) begin
                out_valid_r <= 1'b0;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({grant_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
            pending_r <= pending_nxt_s;
            if (orphan_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign rq_ready_o       = ~pending_r;
    assign req_addr_valid_o = out_valid_r;
    assign req_addr_vaddr_o = out_vaddr_r;
    assign req_addr_qpn_o   = out_qpn_r;
    assign rsp_data_o       = resp_addr_data_i;
    assign err_orphan_o     = err_r;

    roce_stack_addr_lookup_arbiter_chk u_chk (
        .clk_i     (clk_i),
        .aresetn_i (aresetn_i),
        .push      (grant_s),
        .cnt       (cnt_r)
    );

endmodule

// File: doc/roce_stack_addr_lookup_arbiter.md
# roce_stack_addr_lookup_arbiter

Shares the single virtual-to-physical address-lookup port of the RoCE protection/translation table between the two request handlers: index 0 is the read-path handler, index 1 is the write-path handler. The block arbitrates lookup requests round-robin and registers the winning request toward the table. It records grant order in a 2-entry order FIFO and steers each in-order table response back to the requester that issued it. It sits between the request handlers and the translation table inside the RoCE stack wrapper.

## Interface
- No parameters. Each requester has at most one lookup outstanding, so the order FIFO depth is fixed at 2.
- clk_i  in  1  sole clock
- aresetn_i  in  1  reset: synchronous, active-low
- rq_valid_i  in  [1:0]  per-requester lookup request; held high until that requester's response handshake
- rq_ready_o  out  [1:0]  requester may issue (= !pending[i])
- rq_vaddr_i  in  [1:0][63:0]  lookup virtual address
- rq_qpn_i  in  [1:0][15:0]  lookup QPN
- rsp_valid_o  out  [1:0]  response for requester i
- rsp_ready_i  in  [1:0]  requester i accepts response
- rsp_data_o  out  dma_req_t  response payload, broadcast to both requesters
- req_addr_valid_o  out  1  lookup request to table (registered)
- req_addr_ready_i  in  1  table accepts request
- req_addr_vaddr_o  out  64  registered vaddr
- req_addr_qpn_o  out  16  registered QPN
- resp_addr_valid_i  in  1  table response valid
- resp_addr_ready_o  out  1  response accepted
- resp_addr_data_i  in  dma_req_t  table response
- err_orphan_o  out  1  sticky flag: a response arrived with no lookup outstanding

## Operation
- State:
  - pending[1:0]: set on grant, cleared on that requester's response handshake.
  - rr_q: 1-bit round-robin pointer.
  - Output slot: out_valid_q, out_vaddr_q, out_qpn_q.
  - Order FIFO: 2 entries of 1-bit requester id, with wr_ptr, rd_ptr and a 2-bit count.
- Eligibility: elig[i] = rq_valid_i[i] & !pending[i].
- Grant condition: at least one requester is eligible, and the slot is free (out_valid_q=0) or drains this cycle (req_addr_valid_o & req_addr_ready_i).
- Arbitration:
  - If only one requester is eligible, it wins.
  - If both are eligible, requester rr_q wins and rr_q is set to the other requester.
  - rr_q changes only when both are eligible.
- On grant:
  - Load the winner's vaddr and qpn into the slot and set out_valid_q.
  - Set pending[winner].
  - Push the winner's id into the order FIFO.
- Slot contents stay stable while req_addr_valid_o=1 and req_addr_ready_i=0.
- Response steering:
  - When count>0, head = FIFO[rd_ptr].
  - rsp_valid_o[head] = resp_addr_valid_i; the other rsp_valid_o bit is 0.
  - resp_addr_ready_o = rsp_ready_i[head].
  - rsp_data_o = resp_addr_data_i (combinational passthrough).
  - On handshake: pop the FIFO and clear pending[head].
- Orphan response (count=0):
  - resp_addr_ready_o=1, so the response is dropped.
  - rsp_valid_o=0.
  - err_orphan_o is set; only reset clears it.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Count can never exceed 2 because each requester has at most one pending lookup. A push at count=2 is unreachable; an assertion flags it.
- A requester's rq_valid_i during its own response-handshake cycle is ignored, because pending is still set. A new request from that requester is considered from the next cycle.

## Timing
- Reset values:
  - req_addr_valid_o=0, req_addr_vaddr_o=0, req_addr_qpn_o=0.
  - rsp_valid_o=0, rq_ready_o=2'b11, err_orphan_o=0.
  - pending=0, rr_q=0, FIFO count and pointers 0.
- Reset asserted mid-operation discards all pending lookups and FIFO contents at the next clock edge. Table responses to requests issued before reset then count as orphans.
- Request latency: elig at cycle t → req_addr_valid_o at t+1.
- Back-to-back issue: a new grant can load the slot in the same cycle the previous request drains, giving one request per cycle of throughput.
- Response path has zero cycles of latency: table response to requester is combinational.
- resp_addr_ready_o depends combinationally on rsp_ready_i and has no dependence on resp_addr_valid_i.

## Test plan
- Single read lookup:
  - Stimulus: rq_valid_i=01, vaddr=0x1000, qpn=0x11, req_addr_ready_i=1.
  - Required: req_addr_valid_o=1 one cycle later with 0x1000/0x11; rq_ready_o[0]=0.
  - Table response paddr=0x8000_0000 → rsp_valid_o=01 carrying that data; rq_ready_o[0]=1 the next cycle.
- Contention:
  - Stimulus: rq_valid_i=11 in the same cycle from reset.
  - Required: requester 0 is issued first and requester 1 one cycle later.
  - Two table responses → rsp_valid_o=01, then 10; rr_q=1 after the first grant.
- Backpressure:
  - Stimulus: req_addr_ready_i=0 for 5 cycles.
  - Required: req_addr_valid_o stays high with stable vaddr/qpn; no second grant until the drain.
- Response backpressure:
  - Stimulus: resp_addr_valid_i=1, rsp_ready_i[head]=0 for 3 cycles.
  - Required: resp_addr_ready_o=0 for those cycles; no pop and pending kept.
- Orphan response:
  - Stimulus: resp_addr_valid_i=1 with no pending lookup.
  - Required: resp_addr_ready_o=1, rsp_valid_o=00, err_orphan_o=1 and held until reset.
- Reset mid-lookup:
  - Stimulus: assert aresetn_i=0 while count=2.
  - Required: all outputs return to their reset values at the next edge; after release, a fresh request from either requester is accepted.
